// File: rtl/boss_chase.sv
// -----------------------------------------------------------------------------
// boss_chase
//   Stage-3 pursuer controller. While game_state reports stage 3 it waits out a
//   spawn delay measured in movement ticks, then moves the boss one pixel
//   toward the player on every tick. When the two sprites overlap it raises
//   caught. The boss passes through walls, so no map lookup is done.
//
// Ports
//   clk          in   system clock (only clock)
//   rst          in   asynchronous, active-high reset
//   game_state   in   [3:0] game state from game_play
//   player_x     in   [8:0] player sprite x
//   player_y     in   [8:0] player sprite y
//   boss_x       out  [8:0] boss sprite x
//   boss_y       out  [8:0] boss sprite y
//   boss_state   out  [3:0] sprite frame: UP 0-2, RIGHT 3-5, LEFT 6-8, DOWN 9-11
//   boss_active  out  high in CHASE and CAUGHT (renderer draws the boss)
//   caught       out  high while in CAUGHT
//
// FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | not in stage 3; outputs parked at spawn/reset values
//   S_WAIT   | in stage 3, counting START_DELAY ticks before the chase
//   S_CHASE  | one step toward the player per tick; overlap checked each cycle
//   S_CAUGHT | position and frame frozen, caught high
// -----------------------------------------------------------------------------
module boss_chase #(
  parameter int STEP_CYCLES = 4_000_000,
  parameter int START_DELAY = 64,
  parameter int SPAWN_X     = 250,
  parameter int SPAWN_Y     = 225,
  parameter int HIT         = 10,
  parameter int STAGE3_CODE = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] game_state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  output logic [8:0] boss_x,
  output logic [8:0] boss_y,
  output logic [3:0] boss_state,
  output logic       boss_active,
  output logic       caught
);

  localparam int TW = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES);
  // The delay counter never holds START_DELAY itself: the tick that would
  // reach it moves the FSM to CHASE and clears the counter instead.
  localparam int DW = (START_DELAY < 2) ? 1 : $clog2(START_DELAY);

  localparam logic [3:0] FRAME_UP    = 4'd0;
  localparam logic [3:0] FRAME_RIGHT = 4'd3;
  localparam logic [3:0] FRAME_LEFT  = 4'd6;
  localparam logic [3:0] FRAME_DOWN  = 4'd9;
  localparam logic [3:0] FRAME_RESET = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_CHASE  = 2'd2,
    S_CAUGHT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tick_cnt, tick_cnt_nxt;
  logic [DW-1:0]   delay_cnt, delay_cnt_nxt;
  logic [8:0]      x_nxt, y_nxt;
  logic [3:0]      frame_nxt;

  logic            in_stage;
  logic            run;
  logic            tick;
  logic [9:0]      dx, dy;
  logic [9:0]      adx, ady;
  logic            overlap;

  // Walk animation: alternate base+1 / base+2; any other current frame
  // (including a direction change) restarts at base+1.
  function automatic logic [3:0] next_frame(input logic [3:0] base,
                                            input logic [3:0] cur);
    next_frame = (cur == base + 4'd1) ? base + 4'd2 : base + 4'd1;
  endfunction

  assign in_stage = (game_state == 4'(STAGE3_CODE));
  assign run      = in_stage && (state != S_IDLE);
  assign tick     = run && (tick_cnt == TW'(STEP_CYCLES - 1));

  always_comb begin
    tick_cnt_nxt = '0;
    if (run && !tick) tick_cnt_nxt = tick_cnt + TW'(1);
  end

  // 10-bit signed differences from the registered boss position; the zero
  // extension keeps the full 0..511 range of both operands.
  assign dx  = {1'b0, player_x} - {1'b0, boss_x};
  assign dy  = {1'b0, player_y} - {1'b0, boss_y};
  assign adx = dx[9] ? (~dx + 10'd1) : dx;
  assign ady = dy[9] ? (~dy + 10'd1) : dy;
  assign overlap = (adx < 10'(HIT)) && (ady < 10'(HIT));

  always_comb begin
    state_nxt     = state;
    delay_cnt_nxt = delay_cnt;
    x_nxt         = boss_x;
    y_nxt         = boss_y;
    frame_nxt     = boss_state;

    if (!in_stage) begin
      state_nxt     = S_IDLE;
      delay_cnt_nxt = '0;
      x_nxt         = 9'(SPAWN_X);
      y_nxt         = 9'(SPAWN_Y);
      frame_nxt     = FRAME_RESET;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_nxt     = S_WAIT;
          delay_cnt_nxt = '0;
          x_nxt         = 9'(SPAWN_X);
          y_nxt         = 9'(SPAWN_Y);
          frame_nxt     = FRAME_RESET;
        end

        S_WAIT: begin
          if (tick) begin
            if (delay_cnt == DW'(START_DELAY - 1)) begin
              state_nxt     = S_CHASE;
              delay_cnt_nxt = '0;
            end else begin
              delay_cnt_nxt = delay_cnt + DW'(1);
            end
          end
        end

        S_CHASE: begin
          // Overlap takes priority over a coincident tick: no move that cycle.
          if (overlap) begin
            state_nxt = S_CAUGHT;
          end else if (tick) begin
            if ((adx >= ady) && (dx != 10'd0)) begin
              if (dx[9]) begin
                x_nxt     = boss_x - 9'd1;
                frame_nxt = next_frame(FRAME_LEFT, boss_state);
              end else begin
                x_nxt     = boss_x + 9'd1;
                frame_nxt = next_frame(FRAME_RIGHT, boss_state);
              end
            end else if (dy != 10'd0) begin
              if (dy[9]) begin
                y_nxt     = boss_y - 9'd1;
                frame_nxt = next_frame(FRAME_UP, boss_state);
              end else begin
                y_nxt     = boss_y + 9'd1;
                frame_nxt = next_frame(FRAME_DOWN, boss_state);
              end
            end
          end
        end

        S_CAUGHT: begin
          state_nxt = S_CAUGHT;
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      delay_cnt <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      delay_cnt <= delay_cnt_nxt;
    end
  end

  // Status flags are registered from the next state so they line up with the
  // state register rather than lagging it by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boss_x      <= 9'(SPAWN_X);
      boss_y      <= 9'(SPAWN_Y);
      boss_state  <= FRAME_RESET;
      boss_active <= 1'b0;
      caught      <= 1'b0;
    end else begin
      boss_x      <= x_nxt;
      boss_y      <= y_nxt;
      boss_state  <= frame_nxt;
      boss_active <= (state_nxt == S_CHASE) || (state_nxt == S_CAUGHT);
      caught      <= (state_nxt == S_CAUGHT);
    end
  end

endmodule

// File: tb/tb_boss_chase.sv
module tb_boss_chase;

  logic       clk;
  logic       rst;
  logic [3:0] game_state;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic [8:0] boss_x;
  logic [8:0] boss_y;
  logic [3:0] boss_state;
  logic       boss_active;
  logic       caught;

  int n_checks = 0;
  int n_fail   = 0;

  boss_chase #(
    .STEP_CYCLES(4),
    .START_DELAY(2),
    .SPAWN_X(250),
    .SPAWN_Y(225),
    .HIT(10),
    .STAGE3_CODE(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_state(game_state),
    .player_x(player_x),
    .player_y(player_y),
    .boss_x(boss_x),
    .boss_y(boss_y),
    .boss_state(boss_state),
    .boss_active(boss_active),
    .caught(caught)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_spawn(input string tag);
    chk({tag, "_x"},      16'(boss_x), 16'd250);
    chk({tag, "_y"},      16'(boss_y), 16'd225);
    chk({tag, "_state"},  16'(boss_state), 16'd6);
    chk({tag, "_active"}, 16'(boss_active), 16'd0);
    chk({tag, "_caught"}, 16'(caught), 16'd0);
  endtask

  initial begin
    rst        = 1'b1;
    game_state = 4'd0;
    player_x   = 9'd65;
    player_y   = 9'd125;
    #2;
    chk_spawn("reset");

    // Spawn delay and first moves
    step(1);
    rst        = 1'b0;
    game_state = 4'd6;
    step(1);                          // IDLE -> WAIT
    chk("wait_entry_active", 16'(boss_active), 16'd0);
    step(4);                          // tick 1
    chk("tick1_active", 16'(boss_active), 16'd0);
    chk("tick1_x", 16'(boss_x), 16'd250);
    step(4);                          // tick 2: WAIT -> CHASE
    chk("tick2_active", 16'(boss_active), 16'd1);
    chk("tick2_x", 16'(boss_x), 16'd250);
    chk("tick2_state", 16'(boss_state), 16'd6);
    // Move only on tick: x stays put for three cycles, moves on the fourth
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("tick3_cyc%0d_x", i), 16'(boss_x), (i == 4) ? 16'd249 : 16'd250);
    end
    chk("tick3_state", 16'(boss_state), 16'd7);
    chk("tick3_y", 16'(boss_y), 16'd225);
    step(4);
    chk("tick4_x", 16'(boss_x), 16'd248);
    chk("tick4_state", 16'(boss_state), 16'd8);
    step(4);
    chk("tick5_x", 16'(boss_x), 16'd247);
    chk("tick5_state", 16'(boss_state), 16'd7);

    // Async reset mid-chase, between clock edges
    #3;
    rst = 1'b1;
    #1;
    chk_spawn("async_rst");
    player_x = 9'd240;
    player_y = 9'd215;
    #2;
    rst = 1'b0;

    // Tie, axis switch and catch
    step(1);                          // IDLE -> WAIT
    chk("tie_wait_active", 16'(boss_active), 16'd0);
    step(4);
    chk("tie_tick1_active", 16'(boss_active), 16'd0);
    step(4);
    chk("tie_chase_active", 16'(boss_active), 16'd1);
    chk("tie_chase_x", 16'(boss_x), 16'd250);
    chk("tie_chase_y", 16'(boss_y), 16'd225);
    step(4);                          // |dx|==|dy|==10 -> x moves
    chk("tie_move_x", 16'(boss_x), 16'd249);
    chk("tie_move_y", 16'(boss_y), 16'd225);
    chk("tie_move_state", 16'(boss_state), 16'd7);
    chk("tie_move_caught", 16'(caught), 16'd0);
    step(4);                          // |dy| larger -> y moves up
    chk("axis_move_x", 16'(boss_x), 16'd249);
    chk("axis_move_y", 16'(boss_y), 16'd224);
    chk("axis_move_state", 16'(boss_state), 16'd1);
    chk("axis_move_caught", 16'(caught), 16'd0);
    step(1);                          // (9,9) overlap -> CAUGHT
    chk("catch_caught", 16'(caught), 16'd1);
    chk("catch_active", 16'(boss_active), 16'd1);
    step(8);                          // two ticks, no movement
    chk("frozen_x", 16'(boss_x), 16'd249);
    chk("frozen_y", 16'(boss_y), 16'd224);
    chk("frozen_state", 16'(boss_state), 16'd1);
    chk("frozen_caught", 16'(caught), 16'd1);

    // Leave the stage while CAUGHT, then retry
    game_state = 4'd8;
    player_x   = 9'd65;
    player_y   = 9'd125;
    step(1);
    chk_spawn("leave");
    game_state = 4'd6;
    step(1);                          // IDLE -> WAIT
    step(4);
    chk("retry_tick1_active", 16'(boss_active), 16'd0);
    step(3);
    chk("retry_pre_tick2_active", 16'(boss_active), 16'd0);
    step(1);
    chk("retry_tick2_active", 16'(boss_active), 16'd1);
    chk("retry_tick2_x", 16'(boss_x), 16'd250);

    // Mid-chase exit with the tick counter part way through
    step(2);
    game_state = 4'd0;
    step(1);
    chk_spawn("midexit");
    step(2);
    chk("midexit_idle_active", 16'(boss_active), 16'd0);
    game_state = 4'd6;
    step(1);                          // IDLE -> WAIT
    step(7);
    chk("reentry_pre_active", 16'(boss_active), 16'd0);
    step(1);                          // second tick lands 8 cycles after WAIT entry
    chk("reentry_active", 16'(boss_active), 16'd1);
    step(4);
    chk("reentry_move_x", 16'(boss_x), 16'd249);
    chk("reentry_move_y", 16'(boss_y), 16'd225);
    chk("reentry_move_state", 16'(boss_state), 16'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
